// File: rtl/mux_pkg.sv
// Shared types and index helpers for the mux scan serializer.
// Start and terminal select indices are derived from the word width and the
// scan direction, so the serializer never needs a separate bit counter.
package mux_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Select width for a given number of mux inputs (at least one bit).
  function automatic int sel_width(input int width);
    return (width < 32'sd2) ? 32'sd1 : $clog2(width);
  endfunction

  // First index presented to the mux for a freshly accepted word.
  function automatic int start_index(input int width, input bit lsb_first);
    return lsb_first ? 32'sd0 : (width - 32'sd1);
  endfunction

  // Index of the final bit of a word; reaching it marks ser_last.
  function automatic int term_index(input int width, input bit lsb_first);
    return lsb_first ? (width - 32'sd1) : 32'sd0;
  endfunction

endpackage

// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial front end wrapped around an external WIDTH:1 mux.
// The accepted word is held on mux_in and mux_sel walks every index; the
// bit the mux returns is forwarded as a valid/ready serial stream.
// The select register doubles as the bit position: the terminal index ends
// the word, so no extra counter is kept.
module mux_scan_serializer
  import mux_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SEL_W     = 3,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] mux_in,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             mux_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_data,
  output logic             ser_last,
  output logic             busy
);

  localparam logic [SEL_W-1:0] START_SEL = SEL_W'(start_index(WIDTH, LSB_FIRST));
  localparam logic [SEL_W-1:0] TERM_SEL  = SEL_W'(term_index(WIDTH, LSB_FIRST));
  localparam logic [SEL_W-1:0] SEL_ONE   = {{(SEL_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] mux_in_r;
  logic [WIDTH-1:0] mux_in_nxt_s;
  logic [SEL_W-1:0] mux_sel_r;
  logic [SEL_W-1:0] mux_sel_nxt_s;
  logic             shifting_s;
  logic             at_term_s;
  logic             load_ready_s;

  assign shifting_s = (state_r == SHIFT);
  assign at_term_s  = (mux_sel_r == TERM_SEL);

  // Next-state, next-index and load acceptance decisions.
  always_comb begin
    state_nxt_s   = state_r;
    mux_in_nxt_s  = mux_in_r;
    mux_sel_nxt_s = mux_sel_r;
    load_ready_s  = 1'b0;
    case (state_r)
      IDLE: begin
        load_ready_s = 1'b1;
        if (load_valid) begin
          mux_in_nxt_s  = load_data;
          mux_sel_nxt_s = START_SEL;
          state_nxt_s   = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          if (at_term_s) begin
            // Last bit leaves this edge: chain straight into the next word.
            load_ready_s = 1'b1;
            if (load_valid) begin
              mux_in_nxt_s  = load_data;
              mux_sel_nxt_s = START_SEL;
              state_nxt_s   = SHIFT;
            end else begin
              state_nxt_s = IDLE;
            end
          end else if (LSB_FIRST) begin
            mux_sel_nxt_s = mux_sel_r + SEL_ONE;
          end else begin
            mux_sel_nxt_s = mux_sel_r - SEL_ONE;
          end
        end else begin
          // Stalled consumer: everything holds, the bit stays valid.
          state_nxt_s = SHIFT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, held word and select index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      mux_in_r  <= {WIDTH{1'b0}};
      mux_sel_r <= {SEL_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      mux_in_r  <= mux_in_nxt_s;
      mux_sel_r <= mux_sel_nxt_s;
    end
  end

  assign load_ready = load_ready_s;
  assign mux_in     = mux_in_r;
  assign mux_sel    = mux_sel_r;
  assign ser_valid  = shifting_s;
  assign ser_data   = mux_out;
  assign ser_last   = shifting_s & at_term_s;
  assign busy       = shifting_s;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Bench for mux_scan_serializer: two instances (LSB-first and MSB-first)
// share stimulus, each with a behavioural 8:1 mux in its loop. Expected
// streams come from the word value and scan order, never from the DUT.
module tb_mux_scan_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] load_data;
  logic       ser_ready;

  logic       a_load_ready, a_mux_out, a_ser_valid, a_ser_data, a_ser_last, a_busy;
  logic [7:0] a_mux_in;
  logic [2:0] a_mux_sel;
  logic       b_load_ready, b_mux_out, b_ser_valid, b_ser_data, b_ser_last, b_busy;
  logic [7:0] b_mux_in;
  logic [2:0] b_mux_sel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural 8:1 select muxes in the loop.
  assign a_mux_out = a_mux_in[a_mux_sel];
  assign b_mux_out = b_mux_in[b_mux_sel];

  mux_scan_serializer #(.WIDTH(8), .SEL_W(3), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(a_load_ready),
    .load_data(load_data), .mux_in(a_mux_in), .mux_sel(a_mux_sel), .mux_out(a_mux_out),
    .ser_valid(a_ser_valid), .ser_ready(ser_ready), .ser_data(a_ser_data),
    .ser_last(a_ser_last), .busy(a_busy)
  );

  mux_scan_serializer #(.WIDTH(8), .SEL_W(3), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(b_load_ready),
    .load_data(load_data), .mux_in(b_mux_in), .mux_sel(b_mux_sel), .mux_out(b_mux_out),
    .ser_valid(b_ser_valid), .ser_ready(ser_ready), .ser_data(b_ser_data),
    .ser_last(b_ser_last), .busy(b_busy)
  );

  // Index k: 0 = LSB-first instance, 1 = MSB-first instance.
  logic       o_lr[2], o_valid[2], o_data[2], o_last[2], o_busy[2];
  logic [7:0] o_min[2];
  logic [2:0] o_sel[2];
  assign o_lr[0] = a_load_ready;  assign o_lr[1] = b_load_ready;
  assign o_valid[0] = a_ser_valid; assign o_valid[1] = b_ser_valid;
  assign o_data[0] = a_ser_data;  assign o_data[1] = b_ser_data;
  assign o_last[0] = a_ser_last;  assign o_last[1] = b_ser_last;
  assign o_busy[0] = a_busy;      assign o_busy[1] = b_busy;
  assign o_min[0] = a_mux_in;     assign o_min[1] = b_mux_in;
  assign o_sel[0] = a_mux_sel;    assign o_sel[1] = b_mux_sel;

  // i-th bit sent for word w in the scan order of instance k.
  function automatic logic exp_bit(input logic [7:0] w, input int k, input int i);
    return (k == 0) ? w[i] : w[7-i];
  endfunction

  // Index presented on mux_sel while the i-th bit is being sent.
  function automatic logic [2:0] exp_sel(input int k, input int i);
    return (k == 0) ? 3'(i) : 3'(7 - i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_valid = 1'b0; load_data = 8'h00; ser_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({o_lr[k], o_valid[k], o_last[k], o_busy[k], o_min[k], o_sel[k]} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0}) begin
          bad++;
          $display("FAIL reset_state k=%0d: got lr=%b v=%b l=%b b=%b in=%h sel=%0d want lr=1 rest 0",
                   k, o_lr[k], o_valid[k], o_last[k], o_busy[k], o_min[k], o_sel[k]);
        end
      end
    end
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (o_valid[k] !== 1'b0 || o_lr[k] !== 1'b1) begin
          bad++;
          $display("FAIL idle_after_reset k=%0d: got valid=%b lr=%b want valid=0 lr=1", k, o_valid[k], o_lr[k]);
        end
      end
      tick();
    end
  endtask

  task automatic test_single();
    logic s_exp[2][8];
    s_exp[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    s_exp[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    load_valid = 1'b1; load_data = 8'hD5; ser_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (o_lr[k] !== 1'b1) begin
        bad++; $display("FAIL single_load_ready k=%0d: got %b want 1", k, o_lr[k]);
      end
    end
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (o_valid[k] !== 1'b1 || o_data[k] !== s_exp[k][i] || o_last[k] !== (i == 7) ||
            o_sel[k] !== exp_sel(k, i) || o_min[k] !== 8'hD5) begin
          bad++;
          $display("FAIL single_bit k=%0d i=%0d: got v=%b d=%b l=%b sel=%0d in=%h want v=1 d=%b l=%b sel=%0d in=d5",
                   k, i, o_valid[k], o_data[k], o_last[k], o_sel[k], o_min[k], s_exp[k][i], (i == 7), exp_sel(k, i));
        end
      end
      tick();
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (o_busy[k] !== 1'b0 || o_valid[k] !== 1'b0 || o_min[k] !== 8'hD5) begin
        bad++;
        $display("FAIL single_end k=%0d: got busy=%b valid=%b in=%h want 0 0 d5", k, o_busy[k], o_valid[k], o_min[k]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    load_valid = 1'b1; load_data = 8'hD5; ser_ready = 1'b1;
    tick();
    load_data = 8'h0F;
    for (int i = 0; i < 16; i++) begin
      w = (i < 8) ? 8'hD5 : 8'h0F;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        total++;
        // load_ready follows ser_last while the consumer is ready.
        if (o_valid[k] !== 1'b1 || o_data[k] !== exp_bit(w, k, i % 8) ||
            o_last[k] !== (i % 8 == 7) || o_lr[k] !== (i % 8 == 7)) begin
          bad++;
          $display("FAIL b2b_bit k=%0d i=%0d: got v=%b d=%b l=%b lr=%b want v=1 d=%b l=%b lr=%b",
                   k, i, o_valid[k], o_data[k], o_last[k], o_lr[k], exp_bit(w, k, i % 8), (i % 8 == 7), (i % 8 == 7));
        end
      end
      tick();
      if (i == 7) load_valid = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (o_busy[k] !== 1'b0) begin
        bad++; $display("FAIL b2b_end k=%0d: got busy=%b want 0", k, o_busy[k]);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] w;
    w = 8'($urandom);
    load_valid = 1'b1; load_data = w; ser_ready = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        ser_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          for (int k = 0; k < 2; k++) begin
            total++;
            if (o_valid[k] !== 1'b1 || o_sel[k] !== exp_sel(k, 3) ||
                o_data[k] !== exp_bit(w, k, 3) || o_lr[k] !== 1'b0) begin
              bad++;
              $display("FAIL stall_hold k=%0d: got v=%b sel=%0d d=%b lr=%b want v=1 sel=%0d d=%b lr=0",
                       k, o_valid[k], o_sel[k], o_data[k], o_lr[k], exp_sel(k, 3), exp_bit(w, k, 3));
            end
          end
          tick();
        end
        ser_ready = 1'b1;
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (o_valid[k] !== 1'b1 || o_data[k] !== exp_bit(w, k, i) || o_last[k] !== (i == 7)) begin
          bad++;
          $display("FAIL stall_bit k=%0d i=%0d w=%h: got v=%b d=%b l=%b want v=1 d=%b l=%b",
                   k, i, w, o_valid[k], o_data[k], o_last[k], exp_bit(w, k, i), (i == 7));
        end
      end
      tick();
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (o_busy[k] !== 1'b0) begin
        bad++; $display("FAIL stall_end k=%0d: got busy=%b want 0", k, o_busy[k]);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    load_valid = 1'b1; load_data = 8'hAA; ser_ready = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (o_valid[k] !== 1'b1 || o_data[k] !== exp_bit(8'hAA, k, 5)) begin
        bad++;
        $display("FAIL mid_bit5 k=%0d: got v=%b d=%b want v=1 d=%b", k, o_valid[k], o_data[k], exp_bit(8'hAA, k, 5));
      end
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({o_lr[k], o_valid[k], o_last[k], o_busy[k], o_min[k], o_sel[k]} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0}) begin
        bad++;
        $display("FAIL mid_async_reset k=%0d: got lr=%b v=%b l=%b b=%b in=%h sel=%0d want lr=1 rest 0",
                 k, o_lr[k], o_valid[k], o_last[k], o_busy[k], o_min[k], o_sel[k]);
      end
    end
    tick();
    rst_n = 1'b1;
    load_valid = 1'b1; load_data = 8'h01;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (o_valid[k] !== 1'b1 || o_data[k] !== exp_bit(8'h01, k, i) || o_last[k] !== (i == 7)) begin
          bad++;
          $display("FAIL post_reset_bit k=%0d i=%0d: got v=%b d=%b l=%b want v=1 d=%b l=%b",
                   k, i, o_valid[k], o_data[k], o_last[k], exp_bit(8'h01, k, i), (i == 7));
        end
      end
      tick();
    end
  endtask

  // Random load/ready traffic against a word-and-position model.
  task automatic test_random();
    bit         active = 1'b0;
    int         pos = 0;
    logic [7:0] cur = 8'h01;
    bit         exp_lr;
    for (int c = 0; c < 400; c++) begin
      load_valid = ($urandom_range(0, 2) != 0);
      load_data  = 8'($urandom);
      ser_ready  = ($urandom_range(0, 3) != 0);
      exp_lr = !active || (pos == 7 && ser_ready);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (o_lr[k] !== exp_lr || o_valid[k] !== active || o_busy[k] !== active || o_min[k] !== cur ||
            (active && (o_data[k] !== exp_bit(cur, k, pos) || o_last[k] !== (pos == 7) ||
                        o_sel[k] !== exp_sel(k, pos))) ||
            (!active && o_last[k] !== 1'b0)) begin
          bad++;
          $display("FAIL random c=%0d k=%0d: got lr=%b v=%b in=%h d=%b l=%b sel=%0d want lr=%b v=%b in=%h pos=%0d",
                   c, k, o_lr[k], o_valid[k], o_min[k], o_data[k], o_last[k], o_sel[k], exp_lr, active, cur, pos);
        end
      end
      if (active && ser_ready) begin
        if (pos == 7) begin
          if (load_valid) begin
            cur = load_data; pos = 0;
          end else begin
            active = 1'b0;
          end
        end else begin
          pos++;
        end
      end else if (!active && load_valid) begin
        active = 1'b1; cur = load_data; pos = 0;
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_data = 8'h00; ser_ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
